// File: rtl/cp0_exc_ctrl.sv
// CP0 exception/interrupt controller: SR, Cause, EPC, PRId, redirect request and ERET return address.
// Optional BadVAddr register (reg 8) enabled by defining CP0_BADVADDR_EN.
module cp0_exc_ctrl #(
    parameter logic [31:0] PRID  = 32'h0000_2019,
    parameter int          EXC_W = 5
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [31:0]      pc_m,
    input  logic             bd_m,
    input  logic [EXC_W-1:0] exc_code,
    input  logic [5:0]       hw_int,
    input  logic             we,
    input  logic [4:0]       addr,
    input  logic [31:0]      wdata,
    output logic [31:0]      rdata,
    input  logic             eret,
    input  logic [31:0]      bad_addr,
    output logic             handle,
    output logic [31:0]      epc_out
);

    logic [5:0]       sr_im;
    logic             sr_exl;
    logic             sr_ie;
    logic             cause_bd;
    logic [5:0]       cause_ip;
    logic [EXC_W-1:0] cause_exc;
    logic [31:0]      epc;
    logic [31:0]      epc_next;
    logic [31:0]      sr_val;
    logic [31:0]      cause_val;
    logic [31:0]      badvaddr_val;
    logic             int_req;
    logic             exc_req;

    assign int_req = (|(cause_ip & sr_im)) & sr_ie & ~sr_exl;
    assign exc_req = (exc_code != '0) & ~sr_exl;
    // Gated by reset so no redirect is requested while the controller is held in reset.
    assign handle  = reset & (int_req | exc_req);
    assign epc_out = epc;

    always_comb begin
        epc_next = bd_m ? (pc_m - 32'd4) : pc_m;
        epc_next[1:0] = 2'b00;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sr_im     <= '0;
            sr_exl    <= 1'b0;
            sr_ie     <= 1'b0;
            cause_bd  <= 1'b0;
            cause_ip  <= '0;
            cause_exc <= '0;
            epc       <= '0;
        end else begin
            cause_ip <= hw_int;
            if (handle) begin
                sr_exl    <= 1'b1;
                cause_exc <= int_req ? '0 : exc_code;
                cause_bd  <= bd_m;
                epc       <= epc_next;
            end else begin
                if (we && addr == 5'd12) begin
                    sr_im  <= wdata[15:10];
                    sr_exl <= wdata[1];
                    sr_ie  <= wdata[0];
                end
                if (we && addr == 5'd14)
                    epc <= wdata;
                // ERET clears EXL after any same-cycle SR write.
                if (eret)
                    sr_exl <= 1'b0;
            end
        end
    end

`ifdef CP0_BADVADDR_EN
    logic [31:0] badvaddr;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            badvaddr <= '0;
        else if (handle && !int_req && (exc_code == EXC_W'(4) || exc_code == EXC_W'(5)))
            badvaddr <= bad_addr;
    end

    assign badvaddr_val = badvaddr;
`else
    logic unused_bad_addr;

    assign unused_bad_addr = ^bad_addr;
    assign badvaddr_val    = '0;
`endif

    always_comb begin
        sr_val         = '0;
        sr_val[15:10]  = sr_im;
        sr_val[1]      = sr_exl;
        sr_val[0]      = sr_ie;
        cause_val      = '0;
        cause_val[31]  = cause_bd;
        cause_val[15:10] = cause_ip;
        cause_val[2 +: EXC_W] = cause_exc;
    end

    always_comb begin
        case (addr)
            5'd8:    rdata = badvaddr_val;
            5'd12:   rdata = sr_val;
            5'd13:   rdata = cause_val;
            5'd14:   rdata = epc;
            5'd15:   rdata = PRID;
            default: rdata = '0;
        endcase
    end

endmodule

// File: tb/tb_cp0_exc_ctrl.sv
// Self-checking bench for cp0_exc_ctrl: directed scenarios plus randomized traffic against a word-level model.
module tb_cp0_exc_ctrl;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [31:0] pc_m = '0;
    logic        bd_m = 1'b0;
    logic [4:0]  exc_code = '0;
    logic [5:0]  hw_int = '0;
    logic        we = 1'b0;
    logic [4:0]  addr = '0;
    logic [31:0] wdata = '0;
    logic [31:0] rdata;
    logic        eret = 1'b0;
    logic [31:0] bad_addr = '0;
    logic        handle;
    logic [31:0] epc_out;

    int n_checks = 0;
    int n_fail = 0;

    // Reference state kept as architectural 32-bit register words.
    logic [31:0] m_sr = '0, m_cause = '0, m_epc = '0, m_bva = '0;

    cp0_exc_ctrl #(.PRID(32'h0000_2019), .EXC_W(5)) dut (
        .clk(clk), .reset(reset), .pc_m(pc_m), .bd_m(bd_m), .exc_code(exc_code),
        .hw_int(hw_int), .we(we), .addr(addr), .wdata(wdata), .rdata(rdata),
        .eret(eret), .bad_addr(bad_addr), .handle(handle), .epc_out(epc_out)
    );

    always #5 clk = ~clk;

    function automatic logic m_int_req();
        return ((m_cause[15:10] & m_sr[15:10]) != 6'd0) && m_sr[0] && !m_sr[1];
    endfunction

    function automatic logic m_handle();
        return reset && (m_int_req() || (exc_code != 5'd0 && !m_sr[1]));
    endfunction

    function automatic logic [31:0] m_read(input logic [4:0] a);
        case (a)
`ifdef CP0_BADVADDR_EN
            5'd8:  return m_bva;
`endif
            5'd12: return m_sr;
            5'd13: return m_cause;
            5'd14: return m_epc;
            5'd15: return 32'h0000_2019;
            default: return 32'h0;
        endcase
    endfunction

    task automatic model_step();
        logic h, ir;
        h  = m_handle();
        ir = m_int_req();
        if (!reset) begin
            m_sr = '0; m_cause = '0; m_epc = '0; m_bva = '0;
            return;
        end
        if (h) begin
            m_sr[1] = 1'b1;
            m_cause[6:2] = ir ? 5'd0 : exc_code;
            m_cause[31] = bd_m;
            m_epc = ((bd_m ? pc_m - 32'd4 : pc_m) / 4) * 4;
            if (!ir && (exc_code == 5'd4 || exc_code == 5'd5)) m_bva = bad_addr;
        end else begin
            if (we && addr == 5'd12) m_sr = wdata & 32'h0000_FC03;
            if (we && addr == 5'd14) m_epc = wdata;
            if (eret) m_sr[1] = 1'b0;
        end
        m_cause[15:10] = hw_int;
    endtask

    task automatic clk_step();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        pc_m = '0; bd_m = 0; exc_code = '0; we = 0; addr = '0; wdata = '0; eret = 0; bad_addr = '0;
    endtask

    task automatic test_reset();
        // Build EPC=0x3010, EXL=1, then drop reset mid-cycle.
        reset = 1'b1; idle(); clk_step();
        we = 1; addr = 5'd14; wdata = 32'h3010; clk_step();
        addr = 5'd12; wdata = 32'h2; clk_step();
        we = 0; #1;
        if (epc_out !== 32'h3010) begin n_fail++; $display("FAIL pre_reset_epc got %h want %h", epc_out, 32'h3010); end
        n_checks++;
        #2 reset = 1'b0; exc_code = 5'd10;
        m_sr = '0; m_cause = '0; m_epc = '0; m_bva = '0;
        #1;
        if (handle !== 1'b0) begin n_fail++; $display("FAIL reset_handle got %b want 0", handle); end
        n_checks++;
        if (epc_out !== 32'h0) begin n_fail++; $display("FAIL reset_epc_out got %h want 0", epc_out); end
        n_checks++;
        for (int a = 12; a <= 15; a++) begin
            addr = 5'(a); #1;
            if (rdata !== (a == 15 ? 32'h2019 : 32'h0)) begin n_fail++; $display("FAIL reset_rdata[%0d] got %h", a, rdata); end
            n_checks++;
        end
        clk_step();
        idle(); reset = 1'b1; clk_step();
    endtask

    task automatic test_exception();
        pc_m = 32'h3008; exc_code = 5'd10; #1;
        if (handle !== 1'b1) begin n_fail++; $display("FAIL exc_handle got %b want 1", handle); end
        n_checks++;
        clk_step();
        if (handle !== 1'b0) begin n_fail++; $display("FAIL exc_no_reenter got %b want 0", handle); end
        n_checks++;
        addr = 5'd14; #1;
        if (rdata !== 32'h3008) begin n_fail++; $display("FAIL exc_epc got %h want 00003008", rdata); end
        n_checks++;
        addr = 5'd13; #1;
        if (rdata !== 32'h0000_0028) begin n_fail++; $display("FAIL exc_cause got %h want 00000028", rdata); end
        n_checks++;
        addr = 5'd12; #1;
        if (rdata !== 32'h2) begin n_fail++; $display("FAIL exc_sr got %h want 00000002", rdata); end
        n_checks++;
        idle(); eret = 1; clk_step(); idle();
    endtask

    task automatic test_delay_slot();
        pc_m = 32'h300C; bd_m = 1; exc_code = 5'd4; bad_addr = 32'h3; #1;
        if (handle !== 1'b1) begin n_fail++; $display("FAIL bd_handle got %b want 1", handle); end
        n_checks++;
        clk_step(); idle();
        addr = 5'd14; #1;
        if (rdata !== 32'h3008) begin n_fail++; $display("FAIL bd_epc got %h want 00003008", rdata); end
        n_checks++;
        addr = 5'd13; #1;
        if (rdata !== 32'h8000_0010) begin n_fail++; $display("FAIL bd_cause got %h want 80000010", rdata); end
        n_checks++;
        addr = 5'd8; #1;
`ifdef CP0_BADVADDR_EN
        if (rdata !== 32'h3) begin n_fail++; $display("FAIL badvaddr got %h want 00000003", rdata); end
`else
        if (rdata !== 32'h0) begin n_fail++; $display("FAIL badvaddr got %h want 00000000", rdata); end
`endif
        n_checks++;
        eret = 1; clk_step(); idle();
    endtask

    task automatic test_interrupt();
        we = 1; addr = 5'd12; wdata = 32'h0000_0401; clk_step(); idle();
        hw_int = 6'b000001; #1;
        if (handle !== 1'b0) begin n_fail++; $display("FAIL int_latency got %b want 0", handle); end
        n_checks++;
        clk_step(); #1;
        if (handle !== 1'b1) begin n_fail++; $display("FAIL int_handle got %b want 1", handle); end
        n_checks++;
        clk_step();
        addr = 5'd13; #1;
        if (rdata !== 32'h0000_0400) begin n_fail++; $display("FAIL int_cause got %h want 00000400", rdata); end
        n_checks++;
        eret = 1; clk_step(); idle();
        exc_code = 5'd10; pc_m = 32'h3020; #1;
        if (handle !== 1'b1) begin n_fail++; $display("FAIL int_prio_handle got %b want 1", handle); end
        n_checks++;
        clk_step(); idle(); hw_int = '0;
        addr = 5'd13; #1;
        if (rdata !== 32'h0000_0400) begin n_fail++; $display("FAIL int_prio_cause got %h want 00000400", rdata); end
        n_checks++;
        clk_step();
        we = 1; addr = 5'd12; wdata = 32'h0; clk_step(); idle();
    endtask

    task automatic test_eret();
        pc_m = 32'h3000; exc_code = 5'd10; clk_step(); idle();
        we = 1; addr = 5'd14; wdata = 32'h3100; clk_step(); idle();
        eret = 1; #1;
        if (epc_out !== 32'h3100) begin n_fail++; $display("FAIL eret_epc_out got %h want 00003100", epc_out); end
        n_checks++;
        clk_step(); idle();
        addr = 5'd12; #1;
        if (rdata !== 32'h0) begin n_fail++; $display("FAIL eret_exl got %h want 00000000", rdata); end
        n_checks++;
    endtask

    task automatic test_write_drop();
        exc_code = 5'd10; pc_m = 32'h3040; we = 1; addr = 5'd12; wdata = 32'hFFFF_FFFF; #1;
        if (handle !== 1'b1) begin n_fail++; $display("FAIL drop_handle got %b want 1", handle); end
        n_checks++;
        clk_step(); idle();
        addr = 5'd12; #1;
        if (rdata !== 32'h0000_0002) begin n_fail++; $display("FAIL drop_sr got %h want 00000002", rdata); end
        n_checks++;
        we = 1; addr = 5'd12; wdata = 32'h0; clk_step(); idle();
    endtask

    task automatic test_random();
        logic [4:0] regs [7] = '{5'd8, 5'd12, 5'd13, 5'd14, 5'd15, 5'd3, 5'd12};
        for (int i = 0; i < 400; i++) begin
            pc_m     = $urandom;
            bd_m     = 1'($urandom_range(0, 1));
            exc_code = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(1, 31)) : 5'd0;
            hw_int   = ($urandom_range(0, 4) == 0) ? 6'($urandom) : 6'd0;
            we       = ($urandom_range(0, 2) == 0);
            addr     = regs[$urandom_range(0, 6)];
            wdata    = $urandom;
            eret     = ($urandom_range(0, 3) == 0);
            bad_addr = $urandom;
            #1;
            if (handle !== m_handle()) begin n_fail++; $display("FAIL rand_handle[%0d] got %b want %b", i, handle, m_handle()); end
            n_checks++;
            if (epc_out !== m_epc) begin n_fail++; $display("FAIL rand_epc_out[%0d] got %h want %h", i, epc_out, m_epc); end
            n_checks++;
            if (rdata !== m_read(addr)) begin n_fail++; $display("FAIL rand_rdata[%0d] reg %0d got %h want %h", i, addr, rdata, m_read(addr)); end
            n_checks++;
            clk_step();
        end
        idle(); hw_int = '0;
    endtask

    initial begin
        @(posedge clk); #1;
        test_reset();
        test_exception();
        test_delay_slot();
        test_interrupt();
        test_eret();
        test_write_drop();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
